// File: rtl/game_pkg.sv
// Shared types and constants for the digit memory game blocks.
package game_pkg;

  localparam int unsigned DIGIT_W       = 4;
  localparam int unsigned MAX_LEN_LIMIT = 16;

  typedef logic [DIGIT_W-1:0] digit_t;
  typedef logic [$clog2(MAX_LEN_LIMIT+1)-1:0] level_t;

  typedef enum logic [2:0] {
    IDLE,
    GEN,
    SHOW,
    GAP,
    INPUT,
    PASS,
    FAIL,
    WIN
  } seq_state_t;

  // Random generator may emit 10..15; fold those back into 0..9.
  function automatic digit_t fold_digit(input digit_t d);
    return (d > digit_t'(9)) ? digit_t'(d - digit_t'(10)) : d;
  endfunction

endpackage

// File: rtl/digit_sequence_controller_if.sv
// Handshake bundle between the round sequencer and its neighbours
// (random generator, keypad decoder, display driver).
interface digit_sequence_controller_if;
  import game_pkg::*;

  logic   start;
  digit_t rand_digit;
  logic   key_valid;
  digit_t key_digit;
  logic   show_valid;
  digit_t show_digit;
  logic   await_input;
  level_t level;
  logic   pass;
  logic   fail;
  logic   win;

  modport master (
    output start, rand_digit, key_valid, key_digit,
    input  show_valid, show_digit, await_input, level, pass, fail, win
  );

  modport slave (
    input  start, rand_digit, key_valid, key_digit,
    output show_valid, show_digit, await_input, level, pass, fail, win
  );

endinterface

// File: rtl/digit_seq_buffer.sv
// Sequence storage: synchronous write, asynchronous read with separate
// playback and checking addresses selected by the controller.
module digit_seq_buffer
  import game_pkg::*;
#(
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned AW      = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  digit_t        wdata,
  input  logic [AW-1:0] play_addr,
  input  logic [AW-1:0] check_addr,
  input  logic          sel_check,
  output digit_t        rdata
);

  digit_t mem [MAX_LEN];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[sel_check ? check_addr : play_addr];

endmodule

// File: rtl/digit_sequence_controller.sv
// Round sequencer: grows the digit sequence, plays it back with fixed
// on/off timing, then checks keypad entries against it.
module digit_sequence_controller
  import game_pkg::*;
#(
  parameter int unsigned MAX_LEN       = 16,
  parameter int unsigned SHOW_CYCLES   = 25_000_000,
  parameter int unsigned GAP_CYCLES    = 12_500_000,
  parameter int unsigned INPUT_TIMEOUT = 250_000_000
) (
  input logic                        clk,
  input logic                        reset,
  digit_sequence_controller_if.slave bus
);

  localparam int unsigned AW        = $clog2(MAX_LEN);
  localparam level_t      MAX_LEN_L = level_t'(MAX_LEN);

  seq_state_t  state, state_n;
  level_t      len, len_n;
  level_t      play_idx, play_idx_n;
  level_t      chk_idx, chk_idx_n;
  logic [31:0] timer, timer_n;
  level_t      last_idx;
  digit_t      rd_digit;
  logic        we;

  assign last_idx = len - level_t'(1);

  digit_seq_buffer #(
    .MAX_LEN (MAX_LEN),
    .AW      (AW)
  ) u_buf (
    .clk        (clk),
    .we         (we),
    .waddr      (last_idx[AW-1:0]),
    .wdata      (fold_digit(bus.rand_digit)),
    .play_addr  (play_idx[AW-1:0]),
    .check_addr (chk_idx[AW-1:0]),
    .sel_check  (state == INPUT),
    .rdata      (rd_digit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      len      <= '0;
      play_idx <= '0;
      chk_idx  <= '0;
      timer    <= '0;
    end else begin
      state    <= state_n;
      len      <= len_n;
      play_idx <= play_idx_n;
      chk_idx  <= chk_idx_n;
      timer    <= timer_n;
    end
  end

  // One down-counter serves SHOW, GAP and the INPUT timeout; it is loaded
  // with (duration-1) on entry so each phase lasts exactly its duration.
  always_comb begin
    state_n    = state;
    len_n      = len;
    play_idx_n = play_idx;
    chk_idx_n  = chk_idx;
    timer_n    = timer;
    we         = 1'b0;
    case (state)
      IDLE, FAIL, WIN: begin
        if (bus.start) begin
          len_n   = level_t'(1);
          state_n = GEN;
        end
      end
      GEN: begin
        we         = 1'b1;
        play_idx_n = '0;
        timer_n    = SHOW_CYCLES - 32'd1;
        state_n    = SHOW;
      end
      SHOW: begin
        if (timer == '0) begin
          timer_n = GAP_CYCLES - 32'd1;
          state_n = GAP;
        end else begin
          timer_n = timer - 32'd1;
        end
      end
      GAP: begin
        if (timer == '0) begin
          if (play_idx == last_idx) begin
            play_idx_n = '0;
            chk_idx_n  = '0;
            timer_n    = INPUT_TIMEOUT - 32'd1;
            state_n    = INPUT;
          end else begin
            play_idx_n = play_idx + level_t'(1);
            timer_n    = SHOW_CYCLES - 32'd1;
            state_n    = SHOW;
          end
        end else begin
          timer_n = timer - 32'd1;
        end
      end
      INPUT: begin
        // A key in the expiry cycle is evaluated instead of timing out.
        if (bus.key_valid) begin
          timer_n = INPUT_TIMEOUT - 32'd1;
          if (bus.key_digit != rd_digit) state_n = FAIL;
          else if (chk_idx == last_idx)  state_n = PASS;
          else                           chk_idx_n = chk_idx + level_t'(1);
        end else if (timer == '0) begin
          state_n = FAIL;
        end else begin
          timer_n = timer - 32'd1;
        end
      end
      PASS: begin
        if (len == MAX_LEN_L) begin
          state_n = WIN;
        end else begin
          len_n   = len + level_t'(1);
          state_n = GEN;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs decode only registered state, so they move solely on clk or reset.
  assign bus.show_valid  = (state == SHOW);
  assign bus.show_digit  = (state == SHOW) ? rd_digit : '0;
  assign bus.await_input = (state == INPUT);
  assign bus.level       = len;
  assign bus.pass        = (state == PASS);
  assign bus.fail        = (state == FAIL);
  assign bus.win         = (state == WIN);

endmodule

// File: tb/tb_digit_sequence_controller.sv
// Randomized bench for digit_sequence_controller with a queue-based game model.
module tb_digit_sequence_controller;
  import game_pkg::*;

  localparam int unsigned ML = 3;
  localparam int unsigned SC = 4;
  localparam int unsigned GC = 2;
  localparam int unsigned TO = 20;
  localparam int unsigned PERIOD = SC + GC;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  digit_sequence_controller_if bus();

  digit_sequence_controller #(
    .MAX_LEN       (ML),
    .SHOW_CYCLES   (SC),
    .GAP_CYCLES    (GC),
    .INPUT_TIMEOUT (TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Game model: digits stored so far, round length, entry position, outcome.
  int m_seq[$];
  int m_len;
  int m_idx;
  bit m_fail;
  bit m_win;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.key_valid  = 1'b0;
    bus.key_digit  = '0;
    bus.rand_digit = '0;
    tick();
    reset = 1'b0;
    tick();
    m_len  = 0;
    m_fail = 1'b0;
    m_win  = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    m_len  = 1;
    m_idx  = 0;
    m_fail = 1'b0;
    m_win  = 1'b0;
    m_seq.delete();
    total++;
    if (bus.level !== 5'd1 || bus.fail !== 1'b0 || bus.win !== 1'b0 || bus.show_valid !== 1'b0) begin
      bad++;
      $display("FAIL start: level=%0d fail=%b win=%b show=%b, want level=1 fail=0 win=0 show=0",
               bus.level, bus.fail, bus.win, bus.show_valid);
    end
  endtask

  // Entered with the DUT in GEN. Checks every playback cycle, then INPUT entry.
  task automatic gen_and_show(input int rd, input bit noise);
    bit exp_v;
    int exp_d;
    int n;
    bus.rand_digit = digit_t'(rd);
    m_seq.push_back((rd > 9) ? rd - 10 : rd);
    n = m_len * PERIOD;
    for (int k = 0; k < n; k++) begin
      if (noise) begin
        bus.start     = 1'($urandom_range(0, 1));
        bus.key_valid = 1'($urandom_range(0, 1));
        bus.key_digit = digit_t'($urandom_range(0, 9));
      end
      tick();
      bus.rand_digit = digit_t'($urandom_range(0, 15));
      exp_v = ((k % PERIOD) < SC);
      exp_d = exp_v ? m_seq[k / PERIOD] : 0;
      total++;
      if (bus.show_valid !== exp_v || bus.show_digit !== digit_t'(exp_d) ||
          bus.await_input !== 1'b0 || bus.level !== level_t'(m_len)) begin
        bad++;
        $display("FAIL playback cyc %0d: valid=%b digit=%0d await=%b level=%0d, want valid=%b digit=%0d await=0 level=%0d",
                 k, bus.show_valid, bus.show_digit, bus.await_input, bus.level, exp_v, exp_d, m_len);
      end
    end
    bus.start     = 1'b0;
    bus.key_valid = 1'b0;
    tick();
    m_idx = 0;
    total++;
    if (bus.await_input !== 1'b1 || bus.show_valid !== 1'b0) begin
      bad++;
      $display("FAIL input_entry: await=%b show=%b, want await=1 show=0", bus.await_input, bus.show_valid);
    end
  endtask

  task automatic idle_wait(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      total++;
      if (bus.await_input !== 1'b1 || bus.fail !== 1'b0) begin
        bad++;
        $display("FAIL idle_wait %0d: await=%b fail=%b, want await=1 fail=0", i, bus.await_input, bus.fail);
      end
    end
  endtask

  task automatic key_press(input int d);
    bus.key_valid = 1'b1;
    bus.key_digit = digit_t'(d);
    tick();
    bus.key_valid = 1'b0;
    if (d != m_seq[m_idx]) begin
      m_fail = 1'b1;
      total++;
      if (bus.fail !== 1'b1 || bus.await_input !== 1'b0 || bus.level !== level_t'(m_len)) begin
        bad++;
        $display("FAIL key_wrong: fail=%b await=%b level=%0d, want fail=1 await=0 level=%0d",
                 bus.fail, bus.await_input, bus.level, m_len);
      end
    end else if (m_idx == m_len - 1) begin
      total++;
      if (bus.pass !== 1'b1 || bus.fail !== 1'b0 || bus.await_input !== 1'b0) begin
        bad++;
        $display("FAIL key_last: pass=%b fail=%b await=%b, want pass=1 fail=0 await=0",
                 bus.pass, bus.fail, bus.await_input);
      end
      tick();
      if (m_len == ML) m_win = 1'b1;
      else m_len++;
      total++;
      if (bus.pass !== 1'b0 || bus.win !== m_win || bus.level !== level_t'(m_len) || bus.show_valid !== 1'b0) begin
        bad++;
        $display("FAIL after_pass: pass=%b win=%b level=%0d show=%b, want pass=0 win=%b level=%0d show=0",
                 bus.pass, bus.win, bus.level, bus.show_valid, m_win, m_len);
      end
    end else begin
      m_idx++;
      total++;
      if (bus.await_input !== 1'b1 || bus.pass !== 1'b0 || bus.fail !== 1'b0) begin
        bad++;
        $display("FAIL key_mid: await=%b pass=%b fail=%b, want await=1 pass=0 fail=0",
                 bus.await_input, bus.pass, bus.fail);
      end
    end
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.key_valid  = 1'b0;
    bus.key_digit  = '0;
    bus.rand_digit = '0;
    #2;
    total++;
    if ({bus.show_valid, bus.show_digit, bus.await_input, bus.level, bus.pass, bus.fail, bus.win} !== 15'd0) begin
      bad++;
      $display("FAIL reset_outputs: show=%b digit=%0d await=%b level=%0d pass=%b fail=%b win=%b, want all 0",
               bus.show_valid, bus.show_digit, bus.await_input, bus.level, bus.pass, bus.fail, bus.win);
    end
    tick();
    reset = 1'b0;
    bus.key_valid = 1'b1;
    bus.key_digit = 4'd3;
    tick();
    bus.key_valid = 1'b0;
    tick();
    total++;
    if ({bus.show_valid, bus.await_input, bus.level, bus.pass, bus.fail, bus.win} !== 10'd0) begin
      bad++;
      $display("FAIL idle_key_ignored: show=%b await=%b level=%0d pass=%b fail=%b win=%b, want all 0",
               bus.show_valid, bus.await_input, bus.level, bus.pass, bus.fail, bus.win);
    end
  endtask

  task automatic test_first_rounds();
    do_reset();
    do_start();
    gen_and_show(7, 1'b0);
    key_press(7);
    gen_and_show(12, 1'b0);
    key_press(7);
    key_press(2);
  endtask

  task automatic test_win();
    do_reset();
    do_start();
    gen_and_show(3, 1'b0);
    key_press(3);
    gen_and_show(9, 1'b0);
    key_press(3);
    key_press(9);
    gen_and_show(0, 1'b0);
    key_press(3);
    key_press(9);
    key_press(0);
    bus.key_valid = 1'b1;
    bus.key_digit = 4'd1;
    tick();
    bus.key_valid = 1'b0;
    tick();
    total++;
    if (bus.win !== 1'b1 || bus.level !== level_t'(ML) || bus.pass !== 1'b0 || bus.fail !== 1'b0) begin
      bad++;
      $display("FAIL win_hold: win=%b level=%0d pass=%b fail=%b, want win=1 level=%0d pass=0 fail=0",
               bus.win, bus.level, bus.pass, bus.fail, ML);
    end
    do_start();
    gen_and_show(int'($urandom_range(0, 15)), 1'b0);
  endtask

  task automatic test_fail();
    do_reset();
    do_start();
    gen_and_show(3, 1'b0);
    key_press(3);
    gen_and_show(9, 1'b0);
    key_press(3);
    key_press(5);
    for (int i = 0; i < 3; i++) begin
      bus.key_valid = 1'b1;
      bus.key_digit = digit_t'($urandom_range(0, 9));
      tick();
      bus.key_valid = 1'b0;
      tick();
      total++;
      if (bus.fail !== 1'b1 || bus.level !== 5'd2 || bus.await_input !== 1'b0 || bus.pass !== 1'b0) begin
        bad++;
        $display("FAIL fail_hold %0d: fail=%b level=%0d await=%b pass=%b, want fail=1 level=2 await=0 pass=0",
                 i, bus.fail, bus.level, bus.await_input, bus.pass);
      end
    end
    do_start();
  endtask

  task automatic test_timeout();
    do_reset();
    do_start();
    gen_and_show(int'($urandom_range(0, 15)), 1'b0);
    idle_wait(TO - 1);
    tick();
    total++;
    if (bus.fail !== 1'b1 || bus.await_input !== 1'b0) begin
      bad++;
      $display("FAIL timeout: fail=%b await=%b, want fail=1 await=0", bus.fail, bus.await_input);
    end
    do_start();
    gen_and_show(int'($urandom_range(0, 15)), 1'b0);
    idle_wait(TO - 1);
    key_press(m_seq[0]);
    gen_and_show(int'($urandom_range(0, 15)), 1'b0);
    idle_wait(int'($urandom_range(0, TO - 1)));
    key_press(m_seq[0]);
    idle_wait(TO - 1);
    key_press(m_seq[1]);
  endtask

  task automatic test_noise_and_reset();
    do_reset();
    do_start();
    gen_and_show(int'($urandom_range(0, 15)), 1'b1);
    key_press(m_seq[0]);
    gen_and_show(int'($urandom_range(0, 15)), 1'b1);
    key_press(m_seq[0]);
    key_press(m_seq[1]);
    do_reset();
    do_start();
    gen_and_show(int'($urandom_range(0, 15)), 1'b0);
    key_press(m_seq[0]);
    bus.rand_digit = 4'd5;
    tick();
    tick();
    tick();
    total++;
    if (bus.show_valid !== 1'b1 || bus.level !== 5'd2) begin
      bad++;
      $display("FAIL midshow_pre: show=%b level=%0d, want show=1 level=2", bus.show_valid, bus.level);
    end
    reset = 1'b1;
    #1;
    total++;
    if ({bus.show_valid, bus.show_digit, bus.await_input, bus.level, bus.pass, bus.fail, bus.win} !== 15'd0) begin
      bad++;
      $display("FAIL midshow_reset: show=%b digit=%0d await=%b level=%0d pass=%b fail=%b win=%b, want all 0",
               bus.show_valid, bus.show_digit, bus.await_input, bus.level, bus.pass, bus.fail, bus.win);
    end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    total++;
    if ({bus.show_valid, bus.await_input, bus.level, bus.pass, bus.fail, bus.win} !== 10'd0) begin
      bad++;
      $display("FAIL post_reset_idle: show=%b await=%b level=%0d pass=%b fail=%b win=%b, want all 0",
               bus.show_valid, bus.await_input, bus.level, bus.pass, bus.fail, bus.win);
    end
  endtask

  task automatic test_random_games();
    int r;
    int d;
    for (int g = 0; g < 10; g++) begin
      do_reset();
      do_start();
      while (!m_fail && !m_win) begin
        gen_and_show(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        r = m_len;
        while (!m_fail && !m_win && m_len == r) begin
          if ($urandom_range(0, 29) == 0) begin
            idle_wait(TO - 1);
            tick();
            m_fail = 1'b1;
            total++;
            if (bus.fail !== 1'b1) begin
              bad++;
              $display("FAIL rand_timeout: fail=%b, want 1", bus.fail);
            end
          end else begin
            idle_wait(int'($urandom_range(0, 4)));
            d = m_seq[m_idx];
            if ($urandom_range(0, 14) == 0) d = (d + 1 + int'($urandom_range(0, 8))) % 10;
            key_press(d);
          end
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_first_rounds();
    test_win();
    test_fail();
    test_timeout();
    test_noise_and_reset();
    test_random_games();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
